ctrl_multicycle_hs: RTL and testbench

- Parametrised successor to the multicycle RV32I core controller.
- Adds variable-latency ready/ack handshakes to instruction and data memory.
- Generates byte-lane strobes from the effective address, detects illegal and misaligned instructions, and traps on memory timeout.
- Halts on ECALL/EBREAK and counts retired instructions. Sits between imem/dmem and the datapath (ALU, regfile, PC, branch unit).

---
 rtl/ctrl_multicycle_hs.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_ctrl_multicycle_hs.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_multicycle_hs.sv
// ============================================================================
//  Module      : ctrl_multicycle_hs
//  Description : Multicycle RV32I controller with ready/ack handshakes to
//                instruction and data memory. It generates byte-lane strobes,
//                traps on illegal/misaligned instructions and on memory
//                timeout, halts on ECALL/EBREAK and counts retired
//                instructions.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ctrl_multicycle_hs #(
    parameter int XLEN    = 32,   // only 32 is supported
    parameter int TIMEOUT = 16,   // 0 disables the memory timeout
    parameter int CNT_W   = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [XLEN-1:0]  inst_i,
    output logic             imem_req_o,
    input  logic             imem_ack_i,
    output logic             dmem_req_o,
    input  logic             dmem_ack_i,
    output logic [3:0]       dmem_we_o,
    input  logic [1:0]       addr_lo_i,
    output logic [XLEN-1:0]  inst_o,
    output logic [6:0]       op_o,
    output logic [2:0]       funct3_o,
    output logic [4:0]       rs1_addr_o,
    output logic [4:0]       rs2_addr_o,
    output logic [4:0]       rd_addr_o,
    output logic [5:0]       alu_op_o,
    output logic             alu_src_a_o,
    output logic             alu_src_b_o,
    output logic [1:0]       result_mux_o,
    output logic             reg_write_o,
    output logic             branch_o,
    output logic [2:0]       branch_op_o,
    output logic             pc_en_o,
    output logic             trap_o,
    output logic [1:0]       trap_cause_o,
    output logic             halt_o,
    output logic [CNT_W-1:0] instret_o
);

    localparam logic [6:0]  c_opc_load   = 7'b0000011;
    localparam logic [6:0]  c_opc_fence  = 7'b0001111;
    localparam logic [6:0]  c_opc_alui   = 7'b0010011;
    localparam logic [6:0]  c_opc_auipc  = 7'b0010111;
    localparam logic [6:0]  c_opc_store  = 7'b0100011;
    localparam logic [6:0]  c_opc_alu    = 7'b0110011;
    localparam logic [6:0]  c_opc_lui    = 7'b0110111;
    localparam logic [6:0]  c_opc_branch = 7'b1100011;
    localparam logic [6:0]  c_opc_jalr   = 7'b1100111;
    localparam logic [6:0]  c_opc_jal    = 7'b1101111;
    localparam logic [6:0]  c_opc_system = 7'b1110011;
    localparam logic [31:0] c_ecall      = 32'h00000073;
    localparam logic [31:0] c_ebreak     = 32'h00100073;
    localparam logic [31:0] c_nop        = 32'h00000013;

    localparam logic [5:0] c_alu_add  = 6'd0;
    localparam logic [5:0] c_alu_sub  = 6'd1;
    localparam logic [5:0] c_alu_sll  = 6'd2;
    localparam logic [5:0] c_alu_slt  = 6'd3;
    localparam logic [5:0] c_alu_sltu = 6'd4;
    localparam logic [5:0] c_alu_xor  = 6'd5;
    localparam logic [5:0] c_alu_srl  = 6'd6;
    localparam logic [5:0] c_alu_sra  = 6'd7;
    localparam logic [5:0] c_alu_or   = 6'd8;
    localparam logic [5:0] c_alu_and  = 6'd9;

    // Branch codes 000..111 reuse the branch funct3; 010/011 are free there
    localparam logic [2:0] c_br_jal  = 3'b010;
    localparam logic [2:0] c_br_jalr = 3'b011;

    localparam int               c_to_w   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [c_to_w-1:0] c_to_lim = c_to_w'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_EXEC  = 3'd1,
        S_MEM   = 3'd2,
        S_WB    = 3'd3,
        S_TRAP  = 3'd4,
        S_HALT  = 3'd5
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [XLEN-1:0]     r_inst;
    logic [c_to_w-1:0]   r_tmo_cnt;
    logic [CNT_W-1:0]    r_instret;
    logic [1:0]          r_trap_cause, w_cause_nxt;

    logic [6:0] w_opc;
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    logic       w_legal, w_is_ld, w_is_st, w_is_sys, w_misalign, w_tmo_hit;
    logic [5:0] w_arith_op, w_dec_alu_op, w_alu_op;
    logic       w_dec_src_a, w_dec_src_b, w_dec_rw, w_dec_br;
    logic [1:0] w_dec_rmux, w_rmux;
    logic [2:0] w_dec_bop, w_bop;
    logic [3:0] w_base_we, w_we;
    logic       w_src_a, w_src_b, w_rw, w_br, w_pc_en, w_retire;
    logic       w_imem_req, w_dmem_req, w_tmo_inc;

    assign w_opc = r_inst[6:0];
    assign w_f3  = r_inst[14:12];
    assign w_f7  = r_inst[31:25];

    // Halfword needs even address, word needs 4-byte alignment
    assign w_misalign = ((w_f3[1:0] == 2'b01) && addr_lo_i[0]) ||
                        ((w_f3[1:0] == 2'b10) && (addr_lo_i != 2'b00));
    assign w_base_we  = (w_f3[1:0] == 2'b00) ? 4'b0001 :
                        (w_f3[1:0] == 2'b01) ? 4'b0011 : 4'b1111;
    assign w_tmo_hit  = (TIMEOUT != 0) && (r_tmo_cnt == c_to_lim);

    // Decode the latched instruction into class, legality and datapath controls
    always_comb begin
        w_legal = 1'b0;  w_is_ld = 1'b0;  w_is_st = 1'b0;  w_is_sys = 1'b0;
        w_dec_alu_op = c_alu_add;  w_dec_src_a = 1'b0;  w_dec_src_b = 1'b0;
        w_dec_rmux = 2'b00;  w_dec_rw = 1'b0;  w_dec_br = 1'b0;  w_dec_bop = 3'b000;
        case (w_f3)
            3'b000:  w_arith_op = w_f7[5] ? c_alu_sub : c_alu_add;
            3'b001:  w_arith_op = c_alu_sll;
            3'b010:  w_arith_op = c_alu_slt;
            3'b011:  w_arith_op = c_alu_sltu;
            3'b100:  w_arith_op = c_alu_xor;
            3'b101:  w_arith_op = w_f7[5] ? c_alu_sra : c_alu_srl;
            3'b110:  w_arith_op = c_alu_or;
            default: w_arith_op = c_alu_and;
        endcase
        if (r_inst[1:0] == 2'b11) begin
            case (w_opc)
                c_opc_alu: begin
                    w_legal = (w_f7 == 7'h00) ||
                              ((w_f7 == 7'h20) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)));
                    w_dec_alu_op = w_arith_op;  w_dec_rw = 1'b1;
                end
                c_opc_alui: begin
                    w_legal = (w_f3 == 3'b001) ? (w_f7 == 7'h00) :
                              (w_f3 == 3'b101) ? ((w_f7 == 7'h00) || (w_f7 == 7'h20)) : 1'b1;
                    w_dec_alu_op = (w_f3 == 3'b000) ? c_alu_add : w_arith_op;
                    w_dec_src_b = 1'b1;  w_dec_rw = 1'b1;
                end
                c_opc_branch: begin
                    w_legal = (w_f3[2:1] != 2'b01);
                    w_dec_src_a = 1'b1;  w_dec_src_b = 1'b1;  w_dec_br = 1'b1;  w_dec_bop = w_f3;
                end
                c_opc_jal: begin
                    w_legal = 1'b1;  w_dec_src_a = 1'b1;  w_dec_src_b = 1'b1;  w_dec_rmux = 2'b01;
                    w_dec_rw = 1'b1;  w_dec_br = 1'b1;  w_dec_bop = c_br_jal;
                end
                c_opc_jalr: begin
                    w_legal = (w_f3 == 3'b000);  w_dec_src_b = 1'b1;  w_dec_rmux = 2'b01;
                    w_dec_rw = 1'b1;  w_dec_br = 1'b1;  w_dec_bop = c_br_jalr;
                end
                c_opc_lui: begin
                    w_legal = 1'b1;  w_dec_src_b = 1'b1;  w_dec_rw = 1'b1;
                end
                c_opc_auipc: begin
                    w_legal = 1'b1;  w_dec_src_a = 1'b1;  w_dec_src_b = 1'b1;  w_dec_rw = 1'b1;
                end
                c_opc_fence:  w_legal = 1'b1;
                c_opc_load: begin
                    w_legal = !((w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111));
                    w_is_ld = 1'b1;  w_dec_src_b = 1'b1;
                end
                c_opc_store: begin
                    w_legal = (w_f3 < 3'b011);  w_is_st = 1'b1;  w_dec_src_b = 1'b1;
                end
                c_opc_system: begin
                    w_legal = (r_inst == c_ecall) || (r_inst == c_ebreak);  w_is_sys = 1'b1;
                end
                default: w_legal = 1'b0;
            endcase
        end
        // An illegal instruction must not drive any datapath control
        if (!w_legal) begin
            w_dec_alu_op = c_alu_add;  w_dec_src_a = 1'b0;  w_dec_src_b = 1'b0;
            w_dec_rmux = 2'b00;  w_dec_rw = 1'b0;  w_dec_br = 1'b0;  w_dec_bop = 3'b000;
        end
    end

    // Next-state and per-state control outputs
    always_comb begin
        w_state_nxt = r_state;  w_cause_nxt = r_trap_cause;
        w_imem_req = 1'b0;  w_dmem_req = 1'b0;  w_we = 4'b0000;  w_tmo_inc = 1'b0;
        w_alu_op = c_alu_add;  w_src_a = 1'b0;  w_src_b = 1'b0;  w_rmux = 2'b00;
        w_rw = 1'b0;  w_br = 1'b0;  w_bop = 3'b000;  w_pc_en = 1'b0;  w_retire = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_imem_req = 1'b1;
                if (imem_ack_i) begin
                    w_state_nxt = S_EXEC;
                end else if (w_tmo_hit) begin
                    w_state_nxt = S_TRAP;  w_cause_nxt = 2'b11;
                end else begin
                    w_tmo_inc = 1'b1;
                end
            end
            S_EXEC: begin
                w_alu_op = w_dec_alu_op;  w_src_a = w_dec_src_a;  w_src_b = w_dec_src_b;
                w_rmux = w_dec_rmux;  w_rw = w_dec_rw;  w_br = w_dec_br;  w_bop = w_dec_bop;
                if (!w_legal) begin
                    w_state_nxt = S_TRAP;  w_cause_nxt = 2'b01;
                end else if (w_is_sys) begin
                    w_state_nxt = S_HALT;
                end else if (w_is_ld || w_is_st) begin
                    if (w_misalign) begin
                        w_state_nxt = S_TRAP;  w_cause_nxt = 2'b10;
                    end else begin
                        w_state_nxt = S_MEM;
                    end
                end else begin
                    w_pc_en = 1'b1;  w_retire = 1'b1;  w_state_nxt = S_FETCH;
                end
            end
            S_MEM: begin
                w_alu_op = w_dec_alu_op;  w_src_a = w_dec_src_a;  w_src_b = w_dec_src_b;
                w_dmem_req = 1'b1;
                w_we = w_is_st ? (w_base_we << addr_lo_i) : 4'b0000;
                if (dmem_ack_i) begin
                    if (w_is_st) begin
                        w_pc_en = 1'b1;  w_retire = 1'b1;  w_state_nxt = S_FETCH;
                    end else begin
                        w_state_nxt = S_WB;
                    end
                end else if (w_tmo_hit) begin
                    w_state_nxt = S_TRAP;  w_cause_nxt = 2'b11;
                end else begin
                    w_tmo_inc = 1'b1;
                end
            end
            S_WB: begin
                w_rmux = 2'b10;  w_rw = 1'b1;  w_pc_en = 1'b1;  w_retire = 1'b1;
                w_state_nxt = S_FETCH;
            end
            S_TRAP, S_HALT: w_state_nxt = r_state;
            default:        w_state_nxt = S_FETCH;
        endcase
    end

    // State, instruction register, timeout counter, trap cause and instret
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= S_FETCH;
            r_inst       <= c_nop;
            r_tmo_cnt    <= '0;
            r_instret    <= '0;
            r_trap_cause <= 2'b00;
        end else begin
            r_state      <= w_state_nxt;
            r_trap_cause <= w_cause_nxt;
            if ((r_state == S_FETCH) && imem_ack_i) r_inst <= inst_i;
            if (w_state_nxt != r_state)             r_tmo_cnt <= '0;
            else if (w_tmo_inc)                     r_tmo_cnt <= r_tmo_cnt + c_to_w'(1);
            if (w_retire)                           r_instret <= r_instret + CNT_W'(1);
        end
    end

    // Every output is held at zero while reset is asserted
    assign imem_req_o   = !rst_i && w_imem_req;
    assign dmem_req_o   = !rst_i && w_dmem_req;
    assign dmem_we_o    = rst_i ? 4'b0000 : w_we;
    assign inst_o       = rst_i ? '0 : r_inst;
    assign op_o         = rst_i ? 7'd0 : w_opc;
    assign funct3_o     = rst_i ? 3'd0 : w_f3;
    assign rs1_addr_o   = (rst_i || (w_opc == c_opc_lui)) ? 5'd0 : r_inst[19:15];
    assign rs2_addr_o   = rst_i ? 5'd0 : r_inst[24:20];
    assign rd_addr_o    = rst_i ? 5'd0 : r_inst[11:7];
    assign alu_op_o     = rst_i ? 6'd0 : w_alu_op;
    assign alu_src_a_o  = !rst_i && w_src_a;
    assign alu_src_b_o  = !rst_i && w_src_b;
    assign result_mux_o = rst_i ? 2'b00 : w_rmux;
    assign reg_write_o  = !rst_i && w_rw;
    assign branch_o     = !rst_i && w_br;
    assign branch_op_o  = rst_i ? 3'b000 : w_bop;
    assign pc_en_o      = !rst_i && w_pc_en;
    assign trap_o       = !rst_i && (r_state == S_TRAP);
    assign trap_cause_o = rst_i ? 2'b00 : r_trap_cause;
    assign halt_o       = !rst_i && (r_state == S_HALT);
    assign instret_o    = rst_i ? '0 : r_instret;

endmodule

`default_nettype wire

// File: tb/tb_ctrl_multicycle_hs.sv
// ============================================================================
//  Module      : tb_ctrl_multicycle_hs
//  Description : Self-checking bench for ctrl_multicycle_hs. Directed
//                instruction scenarios feed a transaction-level model that
//                expands each instruction into its expected per-cycle outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ctrl_multicycle_hs;

    localparam int TO = 4;
    localparam int K_SC = 0, K_LD = 1, K_ST = 2, K_ILL = 3, K_SYS = 4;
    localparam logic [5:0] A_ADD = 6'd0, A_SUB = 6'd1, A_SRA = 6'd7;

    typedef struct packed {
        logic [5:0] op; logic a; logic b; logic [1:0] rm; logic rw; logic br; logic [2:0] bop;
    } ctl_t;

    typedef struct packed {
        logic imem_req; logic dmem_req; logic [3:0] we; logic [5:0] alu_op; logic a; logic b;
        logic [1:0] rm; logic rw; logic br; logic [2:0] bop; logic pc_en; logic trap;
        logic [1:0] cause; logic halt; logic [31:0] instret; logic [31:0] inst; logic [4:0] rs1;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1, imem_ack_i = 1'b0, dmem_ack_i = 1'b0;
    logic [31:0] inst_i = 32'h0;
    logic [1:0]  addr_lo_i = 2'b00;
    logic        imem_req_o, dmem_req_o, alu_src_a_o, alu_src_b_o, reg_write_o, branch_o;
    logic        pc_en_o, trap_o, halt_o;
    logic [3:0]  dmem_we_o;
    logic [31:0] inst_o, instret_o;
    logic [6:0]  op_o;
    logic [2:0]  funct3_o, branch_op_o;
    logic [4:0]  rs1_addr_o, rs2_addr_o, rd_addr_o;
    logic [5:0]  alu_op_o;
    logic [1:0]  result_mux_o, trap_cause_o;

    ctrl_multicycle_hs #(.XLEN(32), .TIMEOUT(TO), .CNT_W(32)) dut (
        .clk_i(clk), .rst_i(rst_i), .inst_i(inst_i), .imem_req_o(imem_req_o),
        .imem_ack_i(imem_ack_i), .dmem_req_o(dmem_req_o), .dmem_ack_i(dmem_ack_i),
        .dmem_we_o(dmem_we_o), .addr_lo_i(addr_lo_i), .inst_o(inst_o), .op_o(op_o),
        .funct3_o(funct3_o), .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
        .rd_addr_o(rd_addr_o), .alu_op_o(alu_op_o), .alu_src_a_o(alu_src_a_o),
        .alu_src_b_o(alu_src_b_o), .result_mux_o(result_mux_o), .reg_write_o(reg_write_o),
        .branch_o(branch_o), .branch_op_o(branch_op_o), .pc_en_o(pc_en_o), .trap_o(trap_o),
        .trap_cause_o(trap_cause_o), .halt_o(halt_o), .instret_o(instret_o)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0, n_err = 0, n_ireq = 0;
    exp_t        q[$];
    exp_t        ce;
    logic [31:0] m_inst = 32'h13, m_instret = 0;
    logic        m_trap = 1'b0, m_halt = 1'b0;
    logic [1:0]  m_cause = 2'b00;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s @%0t: actual=0x%0h required=0x%0h", nm, $time, act, req);
        end
    endtask

    // Cycle-by-cycle compare of the DUT against the expected queue
    always @(negedge clk) begin
        if (q.size() != 0) begin
            ce = q.pop_front();
            if (imem_req_o === 1'b1) n_ireq++;
            chk("imem_req",   32'(imem_req_o),   32'(ce.imem_req));
            chk("dmem_req",   32'(dmem_req_o),   32'(ce.dmem_req));
            chk("dmem_we",    32'(dmem_we_o),    32'(ce.we));
            chk("alu_op",     32'(alu_op_o),     32'(ce.alu_op));
            chk("alu_src_a",  32'(alu_src_a_o),  32'(ce.a));
            chk("alu_src_b",  32'(alu_src_b_o),  32'(ce.b));
            chk("result_mux", 32'(result_mux_o), 32'(ce.rm));
            chk("reg_write",  32'(reg_write_o),  32'(ce.rw));
            chk("branch",     32'(branch_o),     32'(ce.br));
            chk("branch_op",  32'(branch_op_o),  32'(ce.bop));
            chk("pc_en",      32'(pc_en_o),      32'(ce.pc_en));
            chk("trap",       32'(trap_o),       32'(ce.trap));
            chk("trap_cause", 32'(trap_cause_o), 32'(ce.cause));
            chk("halt",       32'(halt_o),       32'(ce.halt));
            chk("instret",    instret_o,         ce.instret);
            chk("inst",       inst_o,            ce.inst);
            chk("op",         32'(op_o),         32'(ce.inst[6:0]));
            chk("funct3",     32'(funct3_o),     32'(ce.inst[14:12]));
            chk("rs1",        32'(rs1_addr_o),   32'(ce.rs1));
            chk("rs2",        32'(rs2_addr_o),   32'(ce.inst[24:20]));
            chk("rd",         32'(rd_addr_o),    32'(ce.inst[11:7]));
        end
    end

    function automatic ctl_t mk(input logic [5:0] op, input logic a, input logic b,
                                input logic [1:0] rm, input logic rw, input logic br,
                                input logic [2:0] bop);
        ctl_t c;
        c.op = op; c.a = a; c.b = b; c.rm = rm; c.rw = rw; c.br = br; c.bop = bop;
        return c;
    endfunction

    // Quiescent outputs for the current architectural view of the model
    function automatic exp_t idle();
        exp_t e;
        e = '0;
        e.inst = m_inst;  e.instret = m_instret;
        e.rs1 = (m_inst[6:0] == 7'b0110111) ? 5'd0 : m_inst[19:15];
        e.trap = m_trap;  e.cause = m_cause;  e.halt = m_halt;
        return e;
    endfunction

    task automatic drive(input logic rst, input logic ia, input logic da,
                         input logic [31:0] ins, input logic [1:0] alo, input exp_t e);
        rst_i = rst;  imem_ack_i = ia;  dmem_ack_i = da;  inst_i = ins;  addr_lo_i = alo;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        for (int k = 0; k < n; k++) drive(1'b1, 1'b1, 1'b1, 32'hFFFFFFFF, 2'b11, '0);
        m_inst = 32'h13;  m_instret = 0;  m_trap = 1'b0;  m_cause = 2'b00;  m_halt = 1'b0;
    endtask

    // Sit in a terminal state while acks arrive; nothing may change
    task automatic hold(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, k[0], !k[0], 32'h00500093, 2'b00, idle());
    endtask

    // Expand one instruction: iw imem wait cycles, dw dmem wait cycles
    // (dw < 0 stops after -dw un-acked memory cycles to allow a reset mid-access)
    task automatic run(input logic [31:0] ins, input int iw, input int kind, input ctl_t c,
                       input int dw, input logic [1:0] alo);
        exp_t e;
        logic [3:0] base;
        logic mis;
        for (int k = 0; k <= iw; k++) begin
            e = idle();  e.imem_req = 1'b1;
            drive(1'b0, k == iw, 1'b0, ins, alo, e);
            if (k != iw && k == TO - 1) begin m_trap = 1'b1; m_cause = 2'b11; return; end
        end
        m_inst = ins;
        e = idle();
        e.alu_op = c.op; e.a = c.a; e.b = c.b; e.rm = c.rm; e.rw = c.rw; e.br = c.br; e.bop = c.bop;
        if (kind == K_SC) begin
            e.pc_en = 1'b1;  drive(1'b0, 1'b0, 1'b0, ins, alo, e);  m_instret++;  return;
        end
        drive(1'b0, 1'b0, 1'b0, ins, alo, e);
        if (kind == K_ILL) begin m_trap = 1'b1; m_cause = 2'b01; return; end
        if (kind == K_SYS) begin m_halt = 1'b1; return; end
        mis = ((ins[13:12] == 2'b01) && alo[0]) || ((ins[13:12] == 2'b10) && (alo != 2'b00));
        if (mis) begin m_trap = 1'b1; m_cause = 2'b10; return; end
        base = (ins[13:12] == 2'b00) ? 4'b0001 : (ins[13:12] == 2'b01) ? 4'b0011 : 4'b1111;
        for (int k = 0; k <= ((dw < 0) ? -dw - 1 : dw); k++) begin
            logic ack;
            ack = (dw >= 0) && (k == dw);
            e = idle();  e.alu_op = c.op;  e.a = c.a;  e.b = c.b;  e.dmem_req = 1'b1;
            e.we = (kind == K_ST) ? 4'(base << alo) : 4'b0000;
            e.pc_en = ack && (kind == K_ST);
            drive(1'b0, 1'b0, ack, ins, alo, e);
            if (!ack && k == TO - 1) begin m_trap = 1'b1; m_cause = 2'b11; return; end
        end
        if (dw < 0) return;
        if (kind == K_LD) begin
            e = idle();  e.rm = 2'b10;  e.rw = 1'b1;  e.pc_en = 1'b1;
            drive(1'b0, 1'b0, 1'b0, ins, alo, e);
        end
        m_instret++;
    endtask

    initial begin
        int ireq0;
        ctl_t ls, none;
        ls   = mk(A_ADD, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 3'b000);
        none = '0;
        @(posedge clk);
        #1;
        do_reset(2);

        // ADDI x1,x0,5 after three imem wait cycles (ack on the timeout limit)
        ireq0 = n_ireq;
        run(32'h00500093, 3, K_SC, mk(A_ADD, 0, 1, 2'b00, 1, 0, 3'b000), 0, 2'b00);
        chk("lit_addi_imem_req_cycles", 32'(n_ireq - ireq0), 32'd4);
        chk("lit_addi_instret", instret_o, 32'd1);

        // SH at addr_lo 10 with two dmem wait cycles
        run(32'h00209123, 0, K_ST, ls, 2, 2'b10);
        chk("lit_sh_instret", instret_o, 32'd2);
        // LW with zero-wait dmem
        run(32'h0000A183, 0, K_LD, ls, 0, 2'b00);
        chk("lit_lw_instret", instret_o, 32'd3);

        run(32'h0020A023, 1, K_ST, ls, 1, 2'b00);                                    // SW
        run(32'h002081A3, 0, K_ST, ls, 0, 2'b11);                                    // SB +3
        run(32'h002081B3, 0, K_SC, mk(A_ADD, 0, 0, 2'b00, 1, 0, 3'b000), 0, 2'b00);  // ADD
        run(32'h402081B3, 2, K_SC, mk(A_SUB, 0, 0, 2'b00, 1, 0, 3'b000), 0, 2'b00);  // SUB
        run(32'h4020D193, 0, K_SC, mk(A_SRA, 0, 1, 2'b00, 1, 0, 3'b000), 0, 2'b00);  // SRAI
        run(32'h00208463, 0, K_SC, mk(A_ADD, 1, 1, 2'b00, 0, 1, 3'b000), 0, 2'b00);  // BEQ
        run(32'h010000EF, 1, K_SC, mk(A_ADD, 1, 1, 2'b01, 1, 1, 3'b010), 0, 2'b00);  // JAL
        run(32'h00008067, 0, K_SC, mk(A_ADD, 0, 1, 2'b01, 1, 1, 3'b011), 0, 2'b00);  // JALR
        run(32'h123452B7, 0, K_SC, mk(A_ADD, 0, 1, 2'b00, 1, 0, 3'b000), 0, 2'b00);  // LUI
        run(32'h00001297, 0, K_SC, mk(A_ADD, 1, 1, 2'b00, 1, 0, 3'b000), 0, 2'b00);  // AUIPC
        run(32'h0000000F, 0, K_SC, none, 0, 2'b00);                                  // FENCE
        chk("lit_instret_14", instret_o, 32'd14);

        // Misaligned SH traps without ever requesting dmem
        run(32'h00209123, 0, K_ST, ls, 0, 2'b01);
        hold(3);
        chk("lit_misalign_cause", 32'(trap_cause_o), 32'd2);
        do_reset(1);

        // All-ones word is illegal
        run(32'hFFFFFFFF, 0, K_ILL, none, 0, 2'b00);
        hold(3);
        chk("lit_illegal_cause", 32'(trap_cause_o), 32'd1);
        do_reset(1);

        // EBREAK halts without retiring
        run(32'h00100073, 0, K_SYS, none, 0, 2'b00);
        hold(3);
        chk("lit_ebreak_halt", 32'(halt_o), 32'd1);
        chk("lit_ebreak_instret", instret_o, 32'd0);
        do_reset(1);

        run(32'h022081B3, 0, K_ILL, none, 0, 2'b00);   // R-type funct7 0x01
        hold(2);
        do_reset(1);

        // imem never acks within the limit
        run(32'h00500093, 6, K_SC, mk(A_ADD, 0, 1, 2'b00, 1, 0, 3'b000), 0, 2'b00);
        hold(3);
        chk("lit_fetch_timeout_cause", 32'(trap_cause_o), 32'd3);
        do_reset(1);

        // dmem never acks within the limit
        run(32'h0000A183, 0, K_LD, ls, 6, 2'b00);
        hold(2);
        do_reset(1);

        // dmem ack exactly on the limit cycle is a normal completion
        run(32'h0000A183, 0, K_LD, ls, 3, 2'b00);
        run(32'h00000073, 0, K_SYS, none, 0, 2'b00);   // ECALL
        hold(2);
        do_reset(1);

        // Reset in the middle of a store, late ack during reset
        run(32'h00500093, 0, K_SC, mk(A_ADD, 0, 1, 2'b00, 1, 0, 3'b000), 0, 2'b00);
        run(32'h0020A023, 0, K_ST, ls, -1, 2'b00);
        do_reset(1);
        run(32'h00500093, 0, K_SC, mk(A_ADD, 0, 1, 2'b00, 1, 0, 3'b000), 0, 2'b00);
        chk("lit_after_reset_instret", instret_o, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
